addr_8_bit: RTL and testbench

//  Registered ripple-carry adder: s = a + b + ci, with carry into the MSB (c6) and carry out (c7).
//  c6/c7 feed signed-overflow detection (ovf = c6 ^ c7) in downstream ALU/flag logic.
//  One clock; all outputs registered; latency 1 cycle.

---
 rtl/addr_pkg.sv | 11 +
 rtl/addr_8_bit_if.sv | 32 +++
 rtl/full_adder.sv | 15 +
 rtl/addr_8_bit.sv | 91 +++++++++
 tb/tb_addr_8_bit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/addr_pkg.sv
// Shared definitions for the registered ripple-carry adder: default width and the majority function.
package addr_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 8;

    // Carry generation of a full adder cell.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/addr_8_bit_if.sv
// Operand/result bundle for addr_8_bit. The ovf signal exists only when ADDR_OVF_EN is defined.
interface addr_8_bit_if #(
    parameter int unsigned WIDTH = addr_pkg::ADDR_WIDTH_DEFAULT
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             c6;
    logic             c7;
`ifdef ADDR_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, ci,
`ifdef ADDR_OVF_EN
        input  ovf,
`endif
        input  out_valid, s, c6, c7
    );

    modport slave (
        input  in_valid, a, b, ci,
`ifdef ADDR_OVF_EN
        output ovf,
`endif
        output out_valid, s, c6, c7
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell used to build the ripple chain.
module full_adder
    import addr_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = maj3(a_i, b_i, ci_i);

endmodule

// File: rtl/addr_8_bit.sv
// Registered ripple-carry adder, {c7,s} = a + b + ci with c6 tap, latency 1.
// Define ADDR_OVF_EN to add the registered signed-overflow output ovf = c6 ^ c7.
module addr_8_bit
    import addr_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_WIDTH_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    addr_8_bit_if.slave bus
);

    // chain[i] is the carry into bit i; chain[i+1] is the carry out of bit i.
    localparam int unsigned C6_IDX = WIDTH - 1;
    localparam int unsigned C7_IDX = WIDTH;

    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] sum_c;

    assign chain[0] = bus.ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a_i  (bus.a[i]),
            .b_i  (bus.b[i]),
            .ci_i (chain[i]),
            .s_o  (sum_c[i]),
            .co_o (chain[i+1])
        );
    end

    logic [WIDTH-1:0] s_q, s_d;
    logic             c6_q, c6_d;
    logic             c7_q, c7_d;
    logic             out_valid_q, out_valid_d;

    // Capture only on in_valid so idle-cycle operands (possibly X) never reach the outputs.
    always_comb begin
        s_d         = s_q;
        c6_d        = c6_q;
        c7_d        = c7_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            s_d         = sum_c;
            c6_d        = chain[C6_IDX];
            c7_d        = chain[C7_IDX];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c6_q        <= 1'b0;
            c7_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c6_q        <= c6_d;
            c7_q        <= c7_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.c6        = c6_q;
    assign bus.c7        = c7_q;
    assign bus.out_valid = out_valid_q;

`ifdef ADDR_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (bus.in_valid) begin
            ovf_d = chain[C6_IDX] ^ chain[C7_IDX];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_addr_8_bit.sv
// Self-checking bench for addr_8_bit: directed vector table, then a long random back-to-back run.
module tb_addr_8_bit;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    addr_8_bit_if #(.WIDTH(W)) bus ();

    addr_8_bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         in_valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         e_valid;
        logic [W-1:0] e_s;
        logic         e_c6;
        logic         e_c7;
        logic         e_ovf;
    } vec_t;

    int n_vec;
    int n_err;

    // Observed outputs packed as {out_valid, c7, c6, ovf, s}; ovf reads 0 when the feature is off.
    function automatic logic [W+3:0] observed();
        logic ovf_v;
`ifdef ADDR_OVF_EN
        ovf_v = bus.ovf;
`else
        ovf_v = 1'b0;
`endif
        return {bus.out_valid, bus.c7, bus.c6, ovf_v, bus.s};
    endfunction

    task automatic check(input string name, input logic [W+3:0] exp);
        logic [W+3:0] got;
        got = observed();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {vld,c7,c6,ovf,s}=%b_%b_%b_%b_%h expected %b_%b_%b_%b_%h",
                     name, got[W+3], got[W+2], got[W+1], got[W], got[W-1:0],
                     exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        rst         = r;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+3:0] expect_of(input logic v, input logic c7, input logic c6,
                                               input logic ovf, input logic [W-1:0] s);
        logic ovf_v;
`ifdef ADDR_OVF_EN
        ovf_v = ovf;
`else
        ovf_v = 1'b0;
`endif
        return {v, c7, c6, ovf_v, s};
    endfunction

    vec_t vecs[13];

    initial begin
        logic [W-1:0] xs;
        logic [W:0]   full;
        logic [W-1:0] low;
        logic [W-1:0] ra, rb;
        logic         rci;
        logic         e_c6, e_c7;
        logic [W-1:0] e_s;

        n_vec = 0;
        n_err = 0;
        xs    = 'x;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.ci       = 1'b0;

        //          rst   vld   a      b      ci    e_vld e_s    c6    c7    ovf
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, xs,    xs,    1'bx, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].in_valid, vecs[i].a, vecs[i].b, vecs[i].ci);
            check($sformatf("vec%0d", i),
                  expect_of(vecs[i].e_valid, vecs[i].e_c7, vecs[i].e_c6, vecs[i].e_ovf, vecs[i].e_s));
        end

        // Back-to-back random operands with a reset pulse mid-stream.
        for (int n = 0; n < 1000; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            if (n == 500) begin
                drive(1'b1, 1'b1, ra, rb, rci);
                check("rand_rst", expect_of(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            end else begin
                drive(1'b0, 1'b1, ra, rb, rci);
                full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rci);
                low  = {1'b0, ra[W-2:0]} + {1'b0, rb[W-2:0]} + W'(rci);
                e_s  = full[W-1:0];
                e_c7 = full[W];
                e_c6 = low[W-1];
                check($sformatf("rand%0d", n), expect_of(1'b1, e_c7, e_c6, e_c6 ^ e_c7, e_s));
            end
        end

        // Idle after the random run: outputs hold the final result, out_valid drops.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("rand_hold", expect_of(1'b0, e_c7, e_c6, e_c6 ^ e_c7, e_s));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
